// File: rtl/pmod_ble_accel_parser_pkg.sv
// Shared types, ASCII constants and the hex-digit decoder for the BLE accelerometer parser.
// Pure definitions: no latency and no backpressure of its own.
package pmod_ble_pkg;

    localparam int OSR_DEFAULT = 16;

    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

`ifdef BLE_PARSE_CHECKSUM_EN
    typedef enum logic [2:0] {P_IDLE, P_X, P_SEP1, P_Y, P_SEP2, P_Z, P_CK, P_EOL} parse_state_e;
`else
    typedef enum logic [2:0] {P_IDLE, P_X, P_SEP1, P_Y, P_SEP2, P_Z, P_EOL} parse_state_e;
`endif

    // Returns {valid, nibble}; valid is 0 for anything that is not 0-9, A-F or a-f.
    function automatic logic [4:0] hex2nib(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, 4'(c[3:0] + 4'd9)};
        end
        return r;
    endfunction

endpackage

// File: rtl/pmod_ble_accel_parser_uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchroniser, OSR-tick divider, midpoint-sampling FSM.
// rx_vld_o/rx_ferr_o pulse 1 clk after the stop-bit midpoint; no backpressure, bytes are never held.
module uart_rx_8n1
    import pmod_ble_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int OSR         = OSR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_vld_o,
    output logic       rx_ferr_o
);
    localparam int DIV_RAW = (CLK_FREQ_HZ + (BAUD * OSR) / 2) / (BAUD * OSR);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW      = (OSR > 1) ? $clog2(OSR) : 1;

    logic          sync1_q, sync2_q, prev_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [OW-1:0] os_q, os_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          vld_q, vld_d, ferr_q, ferr_d;
    logic          tick;

    assign tick = (div_q == CW'(DIV - 1));

    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + 1'b1;
        os_d    = os_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                // A falling edge needs the line high first, which also re-arms after a framing error.
                if (prev_q && !sync2_q) begin
                    state_d = R_START;
                    div_d   = '0;
                    os_d    = '0;
                end
            end
            R_START: if (tick) begin
                if (os_q == OW'(OSR / 2 - 1)) begin
                    state_d = sync2_q ? R_IDLE : R_DATA;
                    os_d    = '0;
                    bit_d   = '0;
                end else begin
                    os_d = os_q + 1'b1;
                end
            end
            R_DATA: if (tick) begin
                if (os_q == OW'(OSR - 1)) begin
                    os_d  = '0;
                    sh_d  = {sync2_q, sh_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = R_STOP;
                end else begin
                    os_d = os_q + 1'b1;
                end
            end
            R_STOP: if (tick) begin
                if (os_q == OW'(OSR - 1)) begin
                    vld_d   = sync2_q;
                    ferr_d  = !sync2_q;
                    state_d = R_IDLE;
                end else begin
                    os_d = os_q + 1'b1;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= R_IDLE;
            div_q   <= '0;
            os_q    <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            div_q   <= div_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data_o = sh_q;
    assign rx_vld_o  = vld_q;
    assign rx_ferr_o = ferr_q;

endmodule

// File: rtl/pmod_ble_accel_parser.sv
// Parses "A<X4>,<Y4>,<Z4>[\r]\n" frames off the BLE tap; commit is 2 clk after the '\n' stop midpoint, no backpressure.
// Define BLE_PARSE_CHECKSUM_EN to require two XOR checksum hex digits after Z.
module pmod_ble_accel_parser
    import pmod_ble_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int OSR         = OSR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_parse_rx,
    output logic [15:0] o_accel_x,
    output logic [15:0] o_accel_y,
    output logic [15:0] o_accel_z,
    output logic        o_accel_valid,
    output logic [15:0] o_frame_cnt,
    output logic [7:0]  o_err_cnt
);
    logic [7:0] rx_data;
    logic       rx_vld, rx_ferr;

    uart_rx_8n1 #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD), .OSR(OSR)) u_rx (
        .clk(clk), .rst(rst), .rx_i(i_parse_rx),
        .rx_data_o(rx_data), .rx_vld_o(rx_vld), .rx_ferr_o(rx_ferr)
    );

    parse_state_e st_q, st_d;
    logic [1:0]   nib_q, nib_d;
    logic [15:0]  sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
    logic [15:0]  ax_q, ax_d, ay_q, ay_d, az_q, az_d, fcnt_q, fcnt_d;
    logic         vld_q, vld_d;
    logic [7:0]   ecnt_q, ecnt_d;
    logic [4:0]   hn;
    logic         is_digit, bad, err_inc;
`ifdef BLE_PARSE_CHECKSUM_EN
    logic [7:0]   ck_acc_q, ck_acc_d, ck_rx_q, ck_rx_d;
`endif

    assign hn = hex2nib(rx_data);
    // 'A' is reserved as the frame start, so it always resyncs; digit ten must arrive as 'a'.
    assign is_digit = hn[4] && (rx_data != CH_A);

    always_comb begin
        st_d = st_q;  nib_d = nib_q;
        sx_d = sx_q;  sy_d = sy_q;  sz_d = sz_q;
        ax_d = ax_q;  ay_d = ay_q;  az_d = az_q;
        vld_d = 1'b0; fcnt_d = fcnt_q;
        bad = 1'b0;   err_inc = 1'b0;
`ifdef BLE_PARSE_CHECKSUM_EN
        ck_acc_d = ck_acc_q;
        ck_rx_d  = ck_rx_q;
`endif
        if (rx_ferr) begin
            st_d    = P_IDLE;
            err_inc = 1'b1;
        end else if (rx_vld) begin
`ifdef BLE_PARSE_CHECKSUM_EN
            if (st_q inside {P_X, P_SEP1, P_Y, P_SEP2, P_Z}) ck_acc_d = ck_acc_q ^ rx_data;
`endif
            unique case (st_q)
                P_IDLE: if (rx_data != CH_A) st_d = P_IDLE; else bad = 1'b0;
                P_X, P_Y, P_Z: begin
                    if (is_digit) begin
                        nib_d = nib_q + 1'b1;
                        if (st_q == P_X)      sx_d = {sx_q[11:0], hn[3:0]};
                        else if (st_q == P_Y) sy_d = {sy_q[11:0], hn[3:0]};
                        else                  sz_d = {sz_q[11:0], hn[3:0]};
                        if (nib_q == 2'd3) begin
                            if (st_q == P_X)      st_d = P_SEP1;
                            else if (st_q == P_Y) st_d = P_SEP2;
`ifdef BLE_PARSE_CHECKSUM_EN
                            else                  st_d = P_CK;
`else
                            else                  st_d = P_EOL;
`endif
                        end
                    end else begin
                        bad = 1'b1;
                    end
                end
                P_SEP1: if (rx_data == CH_COMMA) st_d = P_Y; else bad = 1'b1;
                P_SEP2: if (rx_data == CH_COMMA) st_d = P_Z; else bad = 1'b1;
`ifdef BLE_PARSE_CHECKSUM_EN
                P_CK: begin
                    if (is_digit) begin
                        ck_rx_d = {ck_rx_q[3:0], hn[3:0]};
                        nib_d   = (nib_q == 2'd1) ? 2'd0 : nib_q + 1'b1;
                        if (nib_q == 2'd1) st_d = P_EOL;
                    end else begin
                        bad = 1'b1;
                    end
                end
`endif
                P_EOL: begin
                    if (rx_data == CH_LF) begin
                        st_d = P_IDLE;
`ifdef BLE_PARSE_CHECKSUM_EN
                        if (ck_acc_q != ck_rx_q) err_inc = 1'b1;
                        else
`endif
                        begin
                            ax_d = sx_q;  ay_d = sy_q;  az_d = sz_q;
                            vld_d  = 1'b1;
                            fcnt_d = fcnt_q + 16'd1;
                        end
                    end else if (rx_data != CH_CR) begin
                        bad = 1'b1;
                    end
                end
                default: st_d = P_IDLE;
            endcase
            if (bad) begin
                err_inc = 1'b1;
                st_d    = P_IDLE;
            end
            if (rx_data == CH_A && (bad || st_q == P_IDLE)) begin
                st_d  = P_X;
                nib_d = 2'd0;
                sx_d  = '0;  sy_d = '0;  sz_d = '0;
`ifdef BLE_PARSE_CHECKSUM_EN
                ck_acc_d = CH_A;
`endif
            end
        end
        ecnt_d = (err_inc && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= P_IDLE;  nib_q <= '0;
            sx_q  <= '0;  sy_q <= '0;  sz_q <= '0;
            ax_q  <= '0;  ay_q <= '0;  az_q <= '0;
            vld_q <= 1'b0;  fcnt_q <= '0;  ecnt_q <= '0;
`ifdef BLE_PARSE_CHECKSUM_EN
            ck_acc_q <= '0;  ck_rx_q <= '0;
`endif
        end else begin
            st_q  <= st_d;  nib_q <= nib_d;
            sx_q  <= sx_d;  sy_q <= sy_d;  sz_q <= sz_d;
            ax_q  <= ax_d;  ay_q <= ay_d;  az_q <= az_d;
            vld_q <= vld_d;  fcnt_q <= fcnt_d;  ecnt_q <= ecnt_d;
`ifdef BLE_PARSE_CHECKSUM_EN
            ck_acc_q <= ck_acc_d;  ck_rx_q <= ck_rx_d;
`endif
        end
    end

    assign o_accel_x     = ax_q;
    assign o_accel_y     = ay_q;
    assign o_accel_z     = az_q;
    assign o_accel_valid = vld_q;
    assign o_frame_cnt   = fcnt_q;
    assign o_err_cnt     = ecnt_q;

endmodule

// File: tb/tb_pmod_ble_accel_parser.sv
// Scoreboard bench: expected commits queued at stimulus time, a negedge monitor pops on each valid pulse.
// Runs at a scaled baud (DIV=2, 32 clk per bit) to keep the run short.
module tb_pmod_ble_accel_parser;
    localparam int CLK_HZ  = 50000000;
    localparam int BAUD    = 1562500;
    localparam int BIT_CLK = 32;

    logic        clk = 1'b0;
    logic        rst, rx;
    logic [15:0] o_accel_x, o_accel_y, o_accel_z, o_frame_cnt;
    logic        o_accel_valid;
    logic [7:0]  o_err_cnt;

    pmod_ble_accel_parser #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .OSR(16)) dut (
        .clk(clk), .rst(rst), .i_parse_rx(rx),
        .o_accel_x(o_accel_x), .o_accel_y(o_accel_y), .o_accel_z(o_accel_z),
        .o_accel_valid(o_accel_valid), .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [15:0] x, y, z, f;
        logic [7:0]  e;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic prev_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT_CLK) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic [15:0] f, input logic [7:0] e);
        exp_t t;
        t.x = x; t.y = y; t.z = z; t.f = f; t.e = e;
        sb_q.push_back(t);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_x"}, {16'h0, o_accel_x}, 32'h0);
        chk({tag, "_y"}, {16'h0, o_accel_y}, 32'h0);
        chk({tag, "_z"}, {16'h0, o_accel_z}, 32'h0);
        chk({tag, "_valid"}, {31'h0, o_accel_valid}, 32'h0);
        chk({tag, "_frame_cnt"}, {16'h0, o_frame_cnt}, 32'h0);
        chk({tag, "_err_cnt"}, {24'h0, o_err_cnt}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (o_accel_valid) begin
            exp_t e;
            chk("valid_single_cycle", {31'h0, prev_vld}, 32'h0);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_commit: got x=0x%0h with no commit expected", o_accel_x);
            end else begin
                e = sb_q.pop_front();
                chk("commit_x", {16'h0, o_accel_x}, {16'h0, e.x});
                chk("commit_y", {16'h0, o_accel_y}, {16'h0, e.y});
                chk("commit_z", {16'h0, o_accel_z}, {16'h0, e.z});
                chk("commit_frame_cnt", {16'h0, o_frame_cnt}, {16'h0, e.f});
                chk("commit_err_cnt", {24'h0, o_err_cnt}, {24'h0, e.e});
            end
        end
        prev_vld = o_accel_valid;
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        push(16'h0123, 16'hFF85, 16'h4000, 16'd1, 8'd0);
        send_str("A0123,FF85,4000");
        send_byte(8'h0A, 1'b1);

        push(16'h00FF, 16'h0001, 16'h8000, 16'd2, 8'd0);
        send_str("A00ff,0001,8000");
        send_byte(8'h0D, 1'b1);
        send_byte(8'h0A, 1'b1);

        send_str("A12G4");
        chk("bad_digit_err_cnt", {24'h0, o_err_cnt}, 32'd1);
        push(16'h1111, 16'h2222, 16'h3333, 16'd3, 8'd1);
        send_str("A1111,2222,3333");
        chk("hold_x_before_commit", {16'h0, o_accel_x}, 32'h00FF);
        chk("hold_z_before_commit", {16'h0, o_accel_z}, 32'h8000);
        send_byte(8'h0A, 1'b1);

        push(16'h5678, 16'h0000, 16'h0000, 16'd4, 8'd2);
        send_str("A12A5678,0000,0000");
        send_byte(8'h0A, 1'b1);

        send_byte(8'h55, 1'b0);
        repeat (3 * BIT_CLK) @(negedge clk);
        chk("framing_err_cnt", {24'h0, o_err_cnt}, 32'd3);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT_CLK) @(negedge clk);
        chk("glitch_err_cnt", {24'h0, o_err_cnt}, 32'd3);
        chk("glitch_frame_cnt", {16'h0, o_frame_cnt}, 32'd4);
        chk("glitch_keeps_x", {16'h0, o_accel_x}, 32'h5678);

        send_str("A01");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("midframe_reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        push(16'h7FFF, 16'h8001, 16'h0ABC, 16'd1, 8'd0);
        send_str("A7FFF,8001,0abc");
        send_byte(8'h0A, 1'b1);

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        chk("final_frame_cnt", {16'h0, o_frame_cnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
